// File: rtl/dsp_mem_pkg.sv
// Shared types and sizes for the ADC snapshot memory.
// Contents: capture geometry, FSM state encoding, serializer phase encoding,
// row type and the per-sample threshold trigger helper.
package dsp_mem_pkg;

   localparam int WayWidth    = 64;
   localparam int AdcWidth    = 6;
   localparam int RowWidth    = WayWidth * AdcWidth;
   localparam int Depth       = 16;
   localparam int FrameLength = 64;

   localparam int PtrWidth    = $clog2(Depth);
   // fill count must be able to hold Depth itself
   localparam int FillWidth   = PtrWidth + 1;
   localparam int CmpWidth    = FillWidth + 1;
   localparam int BitCntWidth = $clog2((RowWidth > FrameLength) ? RowWidth : FrameLength);
   localparam int SyncIdxWidth = $clog2(FrameLength);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_POST  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_READ  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      PH_PRE  = 2'd0,
      PH_ROW  = 2'd1,
      PH_POST = 2'd2
   } phase_e;

   typedef logic [RowWidth-1:0] row_t;

   // true when any sample of the row reaches the threshold (unsigned)
   function automatic logic trig_hit(input row_t row, input logic [AdcWidth-1:0] thresh);
      logic hit;
      hit = 1'b0;
      for (int w = 0; w < WayWidth; w++) begin
         if (row[w*AdcWidth +: AdcWidth] >= thresh) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/dsp_mem_serializer.sv
// Frame serializer for the snapshot memory: syncword preamble, Depth rows
// starting at a given index (wrapping), syncword postamble; all MSB first.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clear           drop the frame immediately (abort)
//   i_start           begin a frame; latches i_syncword and i_start_idx
//   i_start_idx       row index of the oldest row
//   i_syncword        pre/postamble word
//   o_rd_addr/i_rd_row combinational row-read port into the row array
//   i_rd_en           advance one bit on the following cycle
//   o_bit, o_vld      current bit and its valid
//   o_last            the bit currently shown is the final frame bit
module dsp_mem_serializer
   import dsp_mem_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clear,
   input  logic                   i_start,
   input  logic [PtrWidth-1:0]    i_start_idx,
   input  logic [FrameLength-1:0] i_syncword,
   output logic [PtrWidth-1:0]    o_rd_addr,
   input  logic [RowWidth-1:0]    i_rd_row,
   input  logic                   i_rd_en,
   output logic                   o_bit,
   output logic                   o_vld,
   output logic                   o_last
);

   phase_e                  r_phase;
   logic [BitCntWidth-1:0]  r_bit_cnt;
   logic [PtrWidth-1:0]     r_row_addr;
   logic [PtrWidth-1:0]     r_rows_left;
   logic [FrameLength-1:0]  r_sync;
   logic                    r_vld;

   logic                    w_bit_tc;
   logic                    w_sel_bit;

   assign w_bit_tc = (r_bit_cnt == '0);

   // bit counter counts down, so it is directly the MSB-first bit index
   always_comb begin
      w_sel_bit = 1'b0;
      case (r_phase)
         PH_PRE, PH_POST: w_sel_bit = r_sync[r_bit_cnt[SyncIdxWidth-1:0]];
         PH_ROW:          w_sel_bit = i_rd_row[r_bit_cnt];
         default:         w_sel_bit = 1'b0;
      endcase
   end

   assign o_bit     = r_vld & w_sel_bit;
   assign o_vld     = r_vld;
   assign o_last    = r_vld && (r_phase == PH_POST) && w_bit_tc;
   assign o_rd_addr = r_row_addr;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_vld       <= 1'b0;
         r_phase     <= PH_PRE;
         r_bit_cnt   <= '0;
         r_row_addr  <= '0;
         r_rows_left <= '0;
         r_sync      <= '0;
      end else if (i_start) begin
         r_vld       <= 1'b1;
         r_phase     <= PH_PRE;
         r_bit_cnt   <= BitCntWidth'(FrameLength - 1);
         r_row_addr  <= i_start_idx;
         r_rows_left <= PtrWidth'(Depth - 1);
         r_sync      <= i_syncword;
      end else if (r_vld && i_rd_en) begin
         if (!w_bit_tc) begin
            r_bit_cnt <= r_bit_cnt - BitCntWidth'(1);
         end else begin
            case (r_phase)
               PH_PRE: begin
                  r_phase   <= PH_ROW;
                  r_bit_cnt <= BitCntWidth'(RowWidth - 1);
               end
               PH_ROW: begin
                  if (r_rows_left == '0) begin
                     r_phase   <= PH_POST;
                     r_bit_cnt <= BitCntWidth'(FrameLength - 1);
                  end else begin
                     r_rows_left <= r_rows_left - PtrWidth'(1);
                     r_row_addr  <= r_row_addr + PtrWidth'(1);
                     r_bit_cnt   <= BitCntWidth'(RowWidth - 1);
                  end
               end
               default: r_vld <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: rtl/dsp_mem_snapshot.sv
// Trigger-driven ADC snapshot memory. Writes way-packed rows into a circular
// buffer while armed, freezes a programmable number of rows after the
// trigger, then dumps the buffer serially (oldest row first) between two
// syncwords.
// Ports:
//   i_clk_dig_mem, i_rst                clock, synchronous active-high reset
//   i_dat_mem, i_dat_vld                row data (way0 in LSBs) and its valid
//   i_arm, i_abort, i_trig              control
//   i_cfg_*                             trigger mode/threshold, post length, syncword
//   i_rd_start, i_rd_en                 readout start and bit strobe
//   o_bit_read_mem, o_bit_vld           serial data out
//   o_state, o_trig_ptr, o_pretrig_short, o_done  status
//
// state | meaning
// IDLE  | waiting for arm
// ARMED | writing rows, watching for trigger
// POST  | writing the post-trigger rows
// HOLD  | buffer frozen, waiting for readout start
// READ  | serializing the frame
module dsp_mem_snapshot
   import dsp_mem_pkg::*;
(
   input  logic                   i_clk_dig_mem,
   input  logic                   i_rst,
   input  logic [RowWidth-1:0]    i_dat_mem,
   input  logic                   i_dat_vld,
   input  logic                   i_arm,
   input  logic                   i_abort,
   input  logic                   i_trig,
   input  logic                   i_cfg_trig_mode,
   input  logic [AdcWidth-1:0]    i_cfg_thresh,
   input  logic [PtrWidth-1:0]    i_cfg_post_len,
   input  logic [FrameLength-1:0] i_cfg_syncword,
   input  logic                   i_rd_start,
   input  logic                   i_rd_en,
   output logic                   o_bit_read_mem,
   output logic                   o_bit_vld,
   output logic [2:0]             o_state,
   output logic [PtrWidth-1:0]    o_trig_ptr,
   output logic                   o_pretrig_short,
   output logic                   o_done
);

   state_e                r_state;
   state_e                w_state_nxt;

   row_t                  r_mem [Depth];

   logic [PtrWidth-1:0]   r_wptr;
   logic [PtrWidth-1:0]   r_trig_ptr;
   logic [PtrWidth-1:0]   r_post_cnt;
   logic [PtrWidth-1:0]   r_post_len;
   logic [FillWidth-1:0]  r_fill;
   logic                  r_trig_mode;
   logic [AdcWidth-1:0]   r_thresh;
   logic                  r_pretrig_short;
   logic                  r_done;

   logic                  w_arm;
   logic                  w_write;
   logic                  w_trig;
   logic                  w_ser_start;
   logic                  w_ser_last;
   logic                  w_ser_vld;
   logic                  w_ser_bit;
   logic [PtrWidth-1:0]   w_rd_addr;
   logic [CmpWidth-1:0]   w_fill_inc;
   logic [CmpWidth-1:0]   w_pre_need;

   assign w_arm       = !i_abort && (r_state == ST_IDLE) && i_arm;
   assign w_write     = !i_abort && i_dat_vld && ((r_state == ST_ARMED) || (r_state == ST_POST));
   assign w_trig      = (r_state == ST_ARMED) && i_dat_vld &&
                        (r_trig_mode ? trig_hit(i_dat_mem, r_thresh) : i_trig);
   assign w_ser_start = !i_abort && (r_state == ST_HOLD) && i_rd_start;

   // rows since arm including the trigger row vs. rows needed before it
   assign w_fill_inc  = {1'b0, r_fill} + CmpWidth'(1);
   assign w_pre_need  = CmpWidth'(Depth) - CmpWidth'(r_post_len);

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (i_arm) w_state_nxt = ST_ARMED;
            ST_ARMED: if (w_trig) w_state_nxt = (r_post_len == '0) ? ST_HOLD : ST_POST;
            ST_POST:  if (w_write && (r_post_cnt == PtrWidth'(1))) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (i_rd_start) w_state_nxt = ST_READ;
            ST_READ:  if (w_ser_last && i_rd_en) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk_dig_mem) begin
      if (i_rst) begin
         r_state         <= ST_IDLE;
         r_wptr          <= '0;
         r_trig_ptr      <= '0;
         r_post_cnt      <= '0;
         r_post_len      <= '0;
         r_fill          <= '0;
         r_trig_mode     <= 1'b0;
         r_thresh        <= '0;
         r_pretrig_short <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= !i_abort && (r_state == ST_READ) && w_ser_last && i_rd_en;

         if (w_arm) begin
            r_trig_mode     <= i_cfg_trig_mode;
            r_thresh        <= i_cfg_thresh;
            r_post_len      <= i_cfg_post_len;
            r_wptr          <= '0;
            r_fill          <= '0;
            r_pretrig_short <= 1'b0;
         end

         if (w_write) begin
            r_wptr <= r_wptr + PtrWidth'(1);
            if (r_fill != FillWidth'(Depth)) r_fill <= r_fill + FillWidth'(1);
            if (w_trig) begin
               r_trig_ptr      <= r_wptr;
               r_post_cnt      <= r_post_len;
               r_pretrig_short <= (w_fill_inc < w_pre_need);
            end else if (r_state == ST_POST) begin
               r_post_cnt <= r_post_cnt - PtrWidth'(1);
            end
         end
      end
   end

   // row storage is deliberately not reset
   always_ff @(posedge i_clk_dig_mem) begin
      if (w_write) r_mem[r_wptr] <= i_dat_mem;
   end

   dsp_mem_serializer u_ser (
      .i_clk       (i_clk_dig_mem),
      .i_rst       (i_rst),
      .i_clear     (i_abort),
      .i_start     (w_ser_start),
      .i_start_idx (r_wptr),
      .i_syncword  (i_cfg_syncword),
      .o_rd_addr   (w_rd_addr),
      .i_rd_row    (r_mem[w_rd_addr]),
      .i_rd_en     (i_rd_en),
      .o_bit       (w_ser_bit),
      .o_vld       (w_ser_vld),
      .o_last      (w_ser_last)
   );

   assign o_bit_read_mem  = w_ser_bit;
   assign o_bit_vld       = w_ser_vld;
   assign o_state         = r_state;
   assign o_trig_ptr      = r_trig_ptr;
   assign o_pretrig_short = r_pretrig_short;
   assign o_done          = r_done;

endmodule
